instr_mem_arbiter: RTL
======================

Name: instr_mem_arbiter

Overview:
- Sits directly upstream of the instruction RAM/boot-ROM wrapper and is the only master driving its en/addr/we/be/wdata port.
- Arbitrates between two masters: the core instruction-fetch port, which is read-only, and the loader/debug port, which reads and writes.
- Returns read data and write acknowledgements to the owning master with fixed one-cycle latency.
- Guarantees the core forward progress with a bounded-starvation counter, and rejects loader writes into the boot-ROM region.

Parameters:
- RAM_SIZE, 32768: instruction RAM size in bytes.
- ADDR_WIDTH, $clog2(RAM_SIZE)+1: byte-address width; the MSB selects the boot ROM.
- DATA_WIDTH, 32: data width.
- MAX_STALL, 4: maximum consecutive denied core-request cycles before the core is forced to win arbitration.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- core_req_i  in  1  core fetch request; held stable until granted
- core_addr_i  in  ADDR_WIDTH  core fetch byte address
- core_gnt_o  out  1  core request accepted this cycle
- core_rvalid_o  out  1  core read data valid
- core_rdata_o  out  DATA_WIDTH  core read data
- ld_req_i  in  1  loader request; held stable until granted
- ld_we_i  in  1  loader write enable
- ld_be_i  in  DATA_WIDTH/8  loader byte enables
- ld_addr_i  in  ADDR_WIDTH  loader byte address
- ld_wdata_i  in  DATA_WIDTH  loader write data
- ld_gnt_o  out  1  loader request accepted this cycle
- ld_rvalid_o  out  1  loader response valid (read data or write acknowledge)
- ld_rdata_o  out  DATA_WIDTH  loader read data
- ld_err_o  out  1  loader error, qualified by ld_rvalid_o
- mem_en_o  out  1  RAM/ROM enable
- mem_addr_o  out  ADDR_WIDTH  RAM/ROM byte address
- mem_we_o  out  1  RAM write enable
- mem_be_o  out  DATA_WIDTH/8  RAM byte enables
- mem_wdata_o  out  DATA_WIDTH  RAM write data
- mem_rdata_i  in  DATA_WIDTH  RAM/ROM read data, valid one cycle after mem_en_o

Behaviour:
- Clock and reset: clk rising edge; rst_n asynchronous, active-low.
- Outputs while rst_n=0: core_gnt_o, ld_gnt_o, mem_en_o, mem_we_o, core_rvalid_o, ld_rvalid_o and ld_err_o are all 0. Address, data and byte-enable outputs are 0. The stall counter and the owner register are cleared.
- Arbitration: combinational, one grant per cycle at most, no bubbles.
  - Default priority is loader over core.
  - Exception: if stall_cnt==MAX_STALL and core_req_i=1, the core wins.
- Stall counter (width $clog2(MAX_STALL+1)):
  - Increments, saturating at MAX_STALL, when core_req_i=1 and core_gnt_o=0.
  - Clears on a core grant or when core_req_i=0.
- Core grant: mem_en_o=1, mem_we_o=0, mem_be_o all ones, mem_addr_o=core_addr_i. The ROM region (MSB=1) is a legal core read.
- Loader grant, normal case: mem_* are driven from the ld_* inputs.
- Loader grant, illegal write: a write (ld_we_i=1) with ld_addr_i[ADDR_WIDTH-1]=1 targets the boot ROM.
  - The request is granted, but mem_en_o=0 and mem_we_o=0.
  - The response cycle carries ld_err_o=1.
- Response pipeline: registered owner state IDLE/CORE/LD/LD_ERR, set in the grant cycle.
  - Next cycle, CORE: core_rvalid_o=1, core_rdata_o=mem_rdata_i.
  - Next cycle, LD: ld_rvalid_o=1 and ld_rdata_o=mem_rdata_i; ld_rdata_o is don't-care (0) for a write.
  - Next cycle, LD_ERR: ld_rvalid_o=1, ld_err_o=1, ld_rdata_o=0.
  - rdata outputs are 0 whenever the matching rvalid is 0.
- Throughput: back-to-back grants every cycle; response N appears in the same cycle as grant N+1.
- Simultaneous requests:
  - Loader granted, core denied, stall counter increments.
  - After MAX_STALL consecutive denials the core is granted the next cycle and the loader is denied for that cycle.
- Reset mid-operation: an outstanding response is dropped. No rvalid is issued after reset release for a pre-reset grant.
- Masters must not change a request before its grant. The arbiter does not check this.

Test Plan:
- Core only: core_req_i=1, addr=0x0010 for 3 cycles -> gnt in each cycle; mem_en_o=1, mem_we_o=0; core_rvalid_o=1 one cycle after each grant, with core_rdata_o equal to the RAM word.
- Loader write then read: write 0xDEADBEEF, be=4'b1111, addr 0x0020; then read 0x0020 -> write ack (ld_rvalid_o=1, ld_err_o=0); read returns 0xDEADBEEF one cycle after its grant.
- Contention, MAX_STALL=4: ld_req_i and core_req_i both held high for 10 cycles -> loader granted in cycles 0-3, core in cycle 4, loader in cycles 5-8, core in cycle 9; never two grants in one cycle.
- Illegal write: loader write to addr 0x8000 -> ld_gnt_o=1 with mem_en_o=0; the next cycle has ld_rvalid_o=1 and ld_err_o=1. A loader read of 0x8000 returns ROM data with ld_err_o=0.
- Reset mid-op: assert rst_n=0 asynchronously in the cycle after a core grant -> core_rvalid_o is immediately 0 and no response arrives after release; stall counter reads 0.
- Alternating masters: interleaved single requests from each master -> each response is routed only to its owner, and no rvalid is ever asserted on the other port.

Source files
------------

// File: rtl/instr_mem_arbiter.sv
// -----------------------------------------------------------------------------
// instr_mem_arbiter
//
// Purpose:
//   Single master of the instruction RAM / boot-ROM wrapper port. Arbitrates
//   between the core instruction-fetch port (read-only) and the loader/debug
//   port (read/write). It returns read data and write acknowledgements to the
//   master that owned the access, always one cycle after the grant.
//   The core is protected from starvation by a saturating stall counter.
//   Loader writes into the boot-ROM half of the address space (address
//   MSB = 1) are accepted but never reach the memory. They are answered with
//   an error response.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   core_req_i / core_addr_i   core fetch request and byte address
//   core_gnt_o                 core request accepted this cycle
//   core_rvalid_o / rdata_o    core read response (one cycle after grant)
//   ld_req_i / ld_we_i / ld_be_i / ld_addr_i / ld_wdata_i
//                              loader request, write enable, byte enables,
//                              byte address and write data
//   ld_gnt_o                   loader request accepted this cycle
//   ld_rvalid_o / ld_rdata_o / ld_err_o
//                              loader response: read data or write ack,
//                              with error flag for rejected ROM writes
//   mem_en_o / mem_addr_o / mem_we_o / mem_be_o / mem_wdata_o
//                              memory command, driven in the grant cycle
//   mem_rdata_i                memory read data, one cycle after mem_en_o
// -----------------------------------------------------------------------------
module instr_mem_arbiter #(
    parameter int RAM_SIZE   = 32768,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE) + 1,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_STALL  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    core_req_i,
    input  logic [ADDR_WIDTH-1:0]   core_addr_i,
    output logic                    core_gnt_o,
    output logic                    core_rvalid_o,
    output logic [DATA_WIDTH-1:0]   core_rdata_o,

    input  logic                    ld_req_i,
    input  logic                    ld_we_i,
    input  logic [DATA_WIDTH/8-1:0] ld_be_i,
    input  logic [ADDR_WIDTH-1:0]   ld_addr_i,
    input  logic [DATA_WIDTH-1:0]   ld_wdata_i,
    output logic                    ld_gnt_o,
    output logic                    ld_rvalid_o,
    output logic [DATA_WIDTH-1:0]   ld_rdata_o,
    output logic                    ld_err_o,

    output logic                    mem_en_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int BE_WIDTH    = DATA_WIDTH / 8;
    localparam int STALL_WIDTH = $clog2(MAX_STALL + 1);
    localparam logic [STALL_WIDTH-1:0] STALL_MAX = STALL_WIDTH'(MAX_STALL);

    // Who owns the response slot in the cycle after a grant.
    typedef enum logic [1:0] {
        OWN_IDLE   = 2'd0,
        OWN_CORE   = 2'd1,
        OWN_LD     = 2'd2,
        OWN_LD_ERR = 2'd3
    } owner_e;

    owner_e                  owner_q, owner_d;
    logic                    ld_wr_q, ld_wr_d;   // loader response is a write ack
    logic [STALL_WIDTH-1:0]  stall_q, stall_d;

    logic core_force;
    logic core_win;
    logic ld_win;
    logic ld_illegal;

    // ------------------------------------------------------------------
    // Arbitration (combinational, at most one winner per cycle)
    // ------------------------------------------------------------------
    // The core overrides the loader's default priority once it has been
    // denied MAX_STALL cycles in a row. Grants are gated with rst_n so that
    // nothing is issued to the memory while reset is asserted, regardless of
    // what the masters are driving.
    assign core_force = core_req_i && (stall_q == STALL_MAX);
    assign core_win   = rst_n && core_req_i && (!ld_req_i || core_force);
    assign ld_win     = rst_n && ld_req_i && !core_win;

    // A loader write with the address MSB set targets the boot ROM.
    assign ld_illegal = ld_we_i && ld_addr_i[ADDR_WIDTH-1];

    assign core_gnt_o = core_win;
    assign ld_gnt_o   = ld_win;

    // ------------------------------------------------------------------
    // Memory command
    // ------------------------------------------------------------------
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (core_win) begin
            mem_en_o   = 1'b1;
            mem_addr_o = core_addr_i;
            mem_be_o   = {BE_WIDTH{1'b1}};
        end else if (ld_win && !ld_illegal) begin
            mem_en_o    = 1'b1;
            mem_we_o    = ld_we_i;
            mem_addr_o  = ld_addr_i;
            mem_be_o    = ld_be_i;
            mem_wdata_o = ld_wdata_i;
        end
        // A rejected ROM write is granted (so the loader can move on) but
        // leaves the memory port idle.
    end

    // ------------------------------------------------------------------
    // Next-state: response owner and stall counter
    // ------------------------------------------------------------------
    always_comb begin
        owner_d = OWN_IDLE;
        ld_wr_d = 1'b0;
        if (core_win) begin
            owner_d = OWN_CORE;
        end else if (ld_win) begin
            owner_d = ld_illegal ? OWN_LD_ERR : OWN_LD;
            ld_wr_d = ld_we_i;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!core_req_i || core_win) begin
            stall_d = '0;
        end else if (stall_q != STALL_MAX) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // Asynchronous reset drops any outstanding response: the owner returns
    // to IDLE immediately, so no rvalid appears for a pre-reset grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_IDLE;
            ld_wr_q <= 1'b0;
            stall_q <= '0;
        end else begin
            owner_q <= owner_d;
            ld_wr_q <= ld_wr_d;
            stall_q <= stall_d;
        end
    end

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    // Data outputs are forced to zero whenever their rvalid is low, so a
    // master never sees another master's read data.
    assign core_rvalid_o = (owner_q == OWN_CORE);
    assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;

    assign ld_rvalid_o = (owner_q == OWN_LD) || (owner_q == OWN_LD_ERR);
    assign ld_err_o    = (owner_q == OWN_LD_ERR);
    assign ld_rdata_o  = ((owner_q == OWN_LD) && !ld_wr_q) ? mem_rdata_i : '0;

`ifndef SYNTHESIS
    a_one_grant : assert property (@(posedge clk) disable iff (!rst_n)
        !(core_gnt_o && ld_gnt_o));
    a_stall_bound : assert property (@(posedge clk) disable iff (!rst_n)
        stall_q <= STALL_MAX);
    a_one_rvalid : assert property (@(posedge clk) disable iff (!rst_n)
        !(core_rvalid_o && ld_rvalid_o));
`endif

endmodule
